// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the fetch sequencing controller: op classes, PC-unit
// branch codes and controller states, used by decoder, PC unit and bench alike.
package fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NORMAL   = 3'd0,
        OP_BRANCH   = 3'd1,
        OP_SEARCH   = 3'd2,
        OP_MEMOP    = 3'd3,
        OP_HALT     = 3'd4,
        OP_LOOP_SET = 3'd5
    } op_e;

    localparam logic [1:0] BR_NEXT = 2'd0;
    localparam logic [1:0] BR_BACK = 2'd1;
    localparam logic [1:0] BR_SKIP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_MEMWAIT = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch sequencing controller: drives the PC unit's Branch/Halt from the op at
// PC, with loop counter, memory-op stall handshake and a saturating cycle counter.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int CYC_W = 16
) (
    input  logic             CLK,
    input  logic             Init,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [CNT_W-1:0] Imm,
    input  logic             Match,
    input  logic             Mem_done,
    output logic [1:0]       Branch,
    output logic             Halt,
    output logic             Mem_req,
    output logic             Done,
    output logic [CNT_W-1:0] Loop_cnt,
    output logic [CYC_W-1:0] Cycles
);

    localparam logic [CYC_W-1:0] CYC_MAX = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] loop_cnt_q, loop_cnt_d;
    logic             done_q, done_d;
    logic [CYC_W-1:0] cycles_q;

    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        loop_cnt_d = loop_cnt_q;
        done_d     = done_q;
        Branch     = BR_NEXT;
        Halt       = 1'b1;
        Mem_req    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Start) state_d = ST_RUN;
            end
            ST_RUN: begin
                Halt = 1'b0;
                case (Op)
                    OP_LOOP_SET: loop_cnt_d = Imm;
                    OP_BRANCH: begin
                        // Counter exhausted means fall through, never wrap.
                        if (loop_cnt_q != '0) begin
                            Branch     = BR_BACK;
                            loop_cnt_d = loop_cnt_q - CNT_W'(1);
                        end
                    end
                    OP_SEARCH: begin
                        if (Match) Branch = BR_SKIP;
                    end
                    OP_MEMOP: begin
                        Mem_req = 1'b1;
                        Halt    = 1'b1;
                        state_d = ST_MEMWAIT;
                    end
                    OP_HALT: begin
                        Halt    = 1'b1;
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEMWAIT: begin
                if (Mem_done) begin
                    Halt    = 1'b0;
                    state_d = ST_RUN;
                end
            end
            default: ;
        endcase

        if (Init) begin
            state_d    = ST_IDLE;
            loop_cnt_d = '0;
            done_d     = 1'b0;
            Branch     = BR_NEXT;
            Halt       = 1'b1;
            Mem_req    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (Init) begin
            state_q    <= ST_IDLE;
            loop_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            loop_cnt_q <= loop_cnt_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (Init) begin
            cycles_q <= '0;
        end else if ((state_q == ST_RUN || state_q == ST_MEMWAIT) && cycles_q != CYC_MAX) begin
            cycles_q <= cycles_q + CYC_W'(1);
        end
    end

    assign Done     = done_q;
    assign Loop_cnt = loop_cnt_q;
    assign Cycles   = cycles_q;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencing controller for the instruction-fetch PC unit.
- Decodes the op class of the instruction currently at PC and drives the PC unit's Branch and Halt inputs.
- Provides a loop counter for backward branches, a skip decision for search ops, a stall handshake for multi-cycle memory ops, and a cycle counter for performance measurement.
- Sits between the instruction decoder and the PC unit; its Init is tied to the PC unit's Init.

Parameters:
- CNT_W, 8, width of the loop counter and of Imm.
- CYC_W, 16, width of the executed-cycle counter.

Ports:
- CLK  input  1  system clock; all state changes on posedge.
- Init  input  1  synchronous, active-high reset; highest priority.
- Start  input  1  begin execution; sampled only in IDLE.
- Op  input  3  decoded op class of the instruction at the current PC.
- Imm  input  CNT_W  loop count operand for LOOP_SET.
- Match  input  1  search-hit flag from the datapath, valid with Op=SEARCH.
- Mem_done  input  1  memory op completion; sampled only in MEMWAIT.
- Branch  output  2  to PC unit: 0 = PC+1, 1 = PC-1, 2 = PC+2; 3 never driven.
- Halt  output  1  to PC unit: hold PC.
- Mem_req  output  1  single-cycle memory op request.
- Done  output  1  program has executed HALT (registered).
- Loop_cnt  output  CNT_W  current loop counter value.
- Cycles  output  CYC_W  cycles spent in RUN plus MEMWAIT, saturating.

Behaviour:
- Op encoding:
  - 0 NORMAL; 1 BRANCH; 2 SEARCH; 3 MEMOP; 4 HALT; 5 LOOP_SET.
  - 6 and 7 are treated as NORMAL.
- State register: IDLE, RUN, MEMWAIT, DONE.
- Branch, Halt and Mem_req are combinational from state and inputs, so the PC unit consumes them on the same edge. Done, Loop_cnt and Cycles are registered.
- Init high (any state, any inputs): next state IDLE, Loop_cnt=0, Cycles=0, Done=0.
  - While Init is high: Branch=0, Halt=1, Mem_req=0.
  - Init overrides every event below in the same cycle.
- IDLE:
  - Outputs: Halt=1, Branch=0, Mem_req=0.
  - Start=1 -> RUN. PC stays 0, so the first instruction executes in the first RUN cycle.
- RUN, per Op:
  - NORMAL: Branch=0, Halt=0.
  - LOOP_SET: Loop_cnt<=Imm; Branch=0, Halt=0.
  - BRANCH with Loop_cnt!=0: Branch=1, Halt=0, Loop_cnt<=Loop_cnt-1.
  - BRANCH with Loop_cnt==0: Branch=0, Halt=0, counter unchanged (no underflow wrap).
  - SEARCH: Branch=2 if Match=1, else Branch=0; Halt=0.
  - MEMOP: Mem_req=1, Halt=1, Branch=0; next state MEMWAIT. Mem_done is ignored in this cycle.
  - HALT: Halt=1, Branch=0; next state DONE.
- MEMWAIT:
  - Halt=1 and Mem_req=0 while Mem_done=0; no timeout.
  - Mem_done=1: Halt=0, Branch=0 (PC advances past MEMOP); next state RUN.
- DONE:
  - Done=1 (set on entry edge), Halt=1, Branch=0.
  - Start is ignored; only Init leaves this state.
- Cycles:
  - Increments by 1 on every posedge where the current state is RUN or MEMWAIT.
  - Holds at all-ones (no wrap); holds in IDLE and DONE.
- Op, Imm and Match are ignored outside RUN. Mem_done is ignored outside MEMWAIT.
- LOOP_SET with Imm=0 is legal: a following BRANCH falls through.

Decomposition:
- Shared package holds:
  - Op-class encodings (OP_NORMAL..OP_LOOP_SET).
  - Branch-code constants (BR_NEXT=0, BR_BACK=1, BR_SKIP=2).
  - The fetch_ctrl state enum, so decoder, PC unit and bench share the values.
- Single module; no sub-module needed. The saturating Cycles counter may be an inline always block.

Test Plan:
- Reset, then Start, then Op=NORMAL x3 -> Branch=0, Halt=0 each cycle; Cycles=3; Done=0.
- LOOP_SET Imm=2, then BRANCH presented 3 times -> Branch=1, 1, 0; Loop_cnt 2->1->0 and stays 0.
- SEARCH with Match=1 -> Branch=2; SEARCH with Match=0 -> Branch=0; Halt=0 both.
- MEMOP with Mem_done asserted 3 cycles after entering MEMWAIT:
  - Mem_req is a 1-cycle pulse; Halt=1 for 4 cycles.
  - Next cycle Halt=0, Branch=0; state returns to RUN; Cycles incremented during every wait cycle.
- HALT op -> Done=1 next cycle, Halt=1 held for 10 cycles, Start pulses ignored, Cycles frozen; then Init -> IDLE, Done=0.
- Init asserted mid-MEMWAIT with Loop_cnt=5 and Cycles=40 -> next cycle state IDLE, Loop_cnt=0, Cycles=0, Mem_req=0, Halt=1; a late Mem_done is ignored.
